// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Receives a framed program image (SYNC, length, data bytes,
//             checksum) over a valid/ready byte stream. Writes the data bytes
//             into the accumulator core's instruction memory. Releases the
//             core from reset only after a complete, checksum-valid image
//             has been loaded.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             in_data/in_valid  - incoming byte stream
//             in_ready          - always 1 once out of reset (no backpressure)
//             mem_we/addr/data  - single-cycle write port into core memory
//             core_rst_n        - active-low reset to the core
//             busy/done/err     - frame in progress / loaded OK / aborted
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int         DEPTH   = 25,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       core_rst_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_in_ready;
    logic            r_mem_we;
    logic [4:0]      r_mem_addr;
    logic [7:0]      r_mem_data;
    logic            r_core_rst_n;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [4:0]      r_addr;
    logic [4:0]      r_len;
    logic [7:0]      r_sum;
    logic [c_TW-1:0] r_tmo;

    logic            w_acc;
    logic            w_in_frame;
    logic            w_tmo_hit;
    logic            w_start;
    logic            w_data_wr;

    assign w_acc      = in_valid & r_in_ready;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
    // Counter holds the number of idle in-frame cycles already elapsed, so the
    // edge at which it equals TIMEOUT-1 is the TIMEOUT-th idle edge.
    assign w_tmo_hit  = w_in_frame && !w_acc && (r_tmo == c_TW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_data_wr    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_acc && (in_data == SYNC)) begin
                    w_state_next = S_LEN;
                    w_start      = 1'b1;
                end
            end
            S_LEN: begin
                if (w_acc) begin
                    if ((in_data == 8'd0) || (in_data > 8'(DEPTH))) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_acc) begin
                    w_data_wr = 1'b1;
                    if (r_addr == (r_len - 5'd1)) begin
                        w_state_next = S_CHK;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERR;
                end
            end
            S_CHK: begin
                if (w_acc) begin
                    w_state_next = (in_data == r_sum) ? S_DONE : S_ERR;
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 5'd0;
            r_mem_data   <= 8'd0;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= 5'd0;
            r_len        <= 5'd0;
            r_sum        <= 8'd0;
            r_tmo        <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_mem_we   <= w_data_wr;
            r_busy     <= (w_state_next == S_LEN) || (w_state_next == S_DATA) ||
                          (w_state_next == S_CHK);

            if (w_start) begin
                r_addr       <= 5'd0;
                r_sum        <= 8'd0;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
                r_core_rst_n <= 1'b0;
            end

            // Length is range-checked before DATA is entered, so 5 bits suffice.
            if ((r_state == S_LEN) && w_acc) begin
                r_len <= in_data[4:0];
            end

            if (w_data_wr) begin
                r_mem_addr <= r_addr;
                r_mem_data <= in_data;
                r_addr     <= r_addr + 5'd1;
                r_sum      <= r_sum + in_data;
            end

            if (w_in_frame && (w_state_next == S_DONE)) begin
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
            end

            if (w_in_frame && (w_state_next == S_ERR)) begin
                r_err <= 1'b1;
            end

            if (w_acc || !w_in_frame) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign core_rst_n = r_core_rst_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire
